vmem_read_arbiter: RTL and testbench
====================================

# vmem_read_arbiter

Arbiter and sequencer for the single combinational read port of the vector image data memory (96×96 8-bit pixels, 8 pixels per read, delivered as 16 lanes × 16 bits with lanes 8–15 zero).

It shares that port between two requesters:
- the CPU vector-load path, which makes random single reads;
- an internal stream walker, which scans the whole image in 8-pixel chunks to a valid/ready consumer.

Responses are registered. The CPU has priority, bounded by a starvation guard for the stream.

## Interface
Parameters:
- IMAGE_WIDTH, 96, pixels per row
- IMAGE_HEIGHT, 96, rows
- LANES, 8, pixels returned per read (chunk stride)
- STARVE_MAX, 4, consecutive CPU grants tolerated while the stream is waiting

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU read request, level, held until granted
- cpu_addr  in  16  CPU pixel base address
- cpu_gnt  out  1  combinational grant, same cycle as the request
- cpu_rvalid  out  1  one-cycle pulse, the cycle after the grant
- cpu_rdata  out  16×16  registered read data
- cpu_err  out  1  pulses with cpu_rvalid when the address is out of range
- strm_start  in  1  pulse; starts a full-image scan when idle
- strm_busy  out  1  scan in progress
- strm_done  out  1  one-cycle pulse after the last chunk handshake
- strm_valid  out  1  stream output valid
- strm_ready  in  1  consumer ready
- strm_data  out  16×16  chunk data
- strm_addr  out  16  base address of the chunk on strm_data
- mem_addr  out  16  to the memory Addr input (combinational)
- mem_rd  in  16×16  from the memory RD output (combinational)

## Operation
- Address limit: AMAX = IMAGE_WIDTH×IMAGE_HEIGHT − LANES (9208). The scan has NCHUNK = 1152 chunks.
- Requester eligibility:
  - The CPU is eligible when cpu_req = 1.
  - The stream is eligible when the state is RUN, chunks remain, and its output buffer is free. The buffer is free when strm_valid = 0, or when strm_valid & strm_ready this cycle.
- Arbitration:
  - The CPU wins.
  - Exception: starve_cnt = STARVE_MAX and the stream is eligible. The stream then wins and starve_cnt clears.
  - starve_cnt increments, saturating, on every CPU grant while the stream is eligible. It clears on every stream grant.
- mem_addr:
  - cpu_addr when the CPU is granted;
  - stream pointer when the stream is granted;
  - 0 otherwise.
- CPU grant:
  - cpu_rdata ← mem_rd and cpu_rvalid ← 1 at the next edge.
  - If cpu_addr > AMAX, cpu_rdata ← 0 and cpu_err ← 1 instead. The access still costs the slot.
- Stream grant: strm_data ← mem_rd, strm_addr ← pointer, strm_valid ← 1, then pointer += LANES.
- strm_valid holds, with data and address stable, until strm_ready.
- Stream FSM:
  - IDLE: pointer = 0. strm_start → RUN.
  - RUN: fetch chunks as above. On the handshake of the chunk at address AMAX: strm_done pulses, strm_busy drops → IDLE.
  - strm_start is ignored while in RUN.
- Lanes 8–15 are passed through unchanged from mem_rd (zero by memory contract).

## Timing
- Reset values: all outputs 0, state IDLE, pointer 0, starve_cnt 0. cpu_gnt is forced 0 while RST_N = 0.
- CPU latency: grant in cycle N, cpu_rvalid in N+1. Back-to-back requests give one response per cycle.
- Stream throughput: one chunk per cycle with strm_ready held high and no CPU traffic. First strm_valid appears 2 cycles after strm_start.
- Simultaneous strm_ready handshake and stream grant: the buffer is overwritten by the next chunk. There is no bubble.
- strm_busy rises the cycle after strm_start and falls the cycle after the final handshake, coincident with strm_done.
- Reset mid-scan: the scan aborts immediately, strm_valid drops, and no strm_done is issued.
- Continuous cpu_req during RUN: the stream gets at least 1 grant per STARVE_MAX + 1 cycles.

## Structure
- Package vmem_pkg holds:
  - vec_t (logic [15:0][15:0]);
  - the stream state enum {IDLE, RUN};
  - localparams AMAX and NCHUNK, derived from the parameters.
- Sub-module vmem_stream_walker holds the FSM, the pointer, the output buffer and done/busy. The top level holds the arbiter, starve counter, CPU response register and mem_addr mux.

## Test plan
- Reset, then single CPU read: cpu_addr = 16 with memory bytes 16..23 = 0x10..0x17 → cpu_gnt in cycle 0; cycle 1 has cpu_rvalid = 1, lanes 0..7 = 0x0010..0x0017, lanes 8..15 = 0.
- CPU read at cpu_addr = 9209 → cpu_rvalid = 1, cpu_err = 1, cpu_rdata all zero.
- Full scan with strm_ready = 1 and no CPU traffic:
  - strm_valid for 1152 consecutive cycles;
  - strm_addr = 0, 8, …, 9208;
  - strm_done exactly once, after the address-9208 handshake.
- Scan with cpu_req held high:
  - stream grants occur every 5th cycle (STARVE_MAX = 4);
  - CPU responses are correct throughout;
  - the scan still completes.
- strm_ready low for 10 cycles mid-scan → strm_data and strm_addr stable, no pointer advance, no lost or duplicated chunk.
- RST_N asserted at chunk 500 → all outputs 0 the same cycle and no strm_done. A fresh strm_start restarts from address 0.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types and geometry for the vector image memory read path.
// The helpers turn image parameters into the last valid chunk base address and the chunk count.
package vmem_pkg;

   typedef logic [15:0][15:0] vec_t;

   typedef enum logic {IDLE, RUN} strm_state_e;

   localparam int IMG_W_DEF   = 96;
   localparam int IMG_H_DEF   = 96;
   localparam int LANES_DEF   = 8;
   localparam int STARVE_DEF  = 4;

   localparam int AMAX   = IMG_W_DEF * IMG_H_DEF - LANES_DEF;
   localparam int NCHUNK = IMG_W_DEF * IMG_H_DEF / LANES_DEF;

   function automatic logic [15:0] amax_f(input int w, input int h, input int l);
      return 16'(w * h - l);
   endfunction

endpackage

// File: rtl/vmem_stream_walker.sv
// Full-image chunk scanner: FSM, fetch pointer, one-entry output buffer, busy/done.
// The buffer may be refilled in the same cycle it is drained, so a ready consumer sees no bubbles.
module vmem_stream_walker
   import vmem_pkg::*;
#(
   parameter int          LANES  = LANES_DEF,
   parameter logic [15:0] AMAX_L = 16'(AMAX)
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        strm_start,
   input  logic        strm_gnt,
   input  vec_t        mem_rd,
   input  logic        strm_ready,
   output logic [15:0] ptr,
   output logic        strm_elig,
   output logic        strm_valid,
   output vec_t        strm_data,
   output logic [15:0] strm_addr,
   output logic        strm_busy,
   output logic        strm_done
);

   strm_state_e state, state_nx;
   logic        hs, hs_last;

   assign hs        = strm_valid & strm_ready;
   assign hs_last   = hs & (strm_addr == AMAX_L);
   assign strm_busy = (state == RUN);
   assign strm_elig = (state == RUN) & (ptr <= AMAX_L) & (~strm_valid | strm_ready);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (strm_start) state_nx = RUN;
         RUN:     if (hs_last)    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr        <= '0;
         strm_valid <= 1'b0;
         strm_data  <= '0;
         strm_addr  <= '0;
         strm_done  <= 1'b0;
      end else begin
         strm_done <= (state == RUN) & hs_last;
         if (state == IDLE) ptr <= '0;
         else if (strm_gnt) ptr <= ptr + 16'(LANES);
         // A grant wins over the drain: the handshaken chunk is replaced in place.
         if (strm_gnt) begin
            strm_valid <= 1'b1;
            strm_data  <= mem_rd;
            strm_addr  <= ptr;
         end else if (hs) begin
            strm_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/vmem_read_arbiter.sv
// Shares the combinational image-memory read port between CPU loads and the stream walker.
// CPU has priority; a saturating starve counter guarantees the stream a slot every STARVE_MAX+1 cycles.
module vmem_read_arbiter
   import vmem_pkg::*;
#(
   parameter int IMAGE_WIDTH  = IMG_W_DEF,
   parameter int IMAGE_HEIGHT = IMG_H_DEF,
   parameter int LANES        = LANES_DEF,
   parameter int STARVE_MAX   = STARVE_DEF
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output vec_t        cpu_rdata,
   output logic        cpu_err,
   input  logic        strm_start,
   output logic        strm_busy,
   output logic        strm_done,
   output logic        strm_valid,
   input  logic        strm_ready,
   output vec_t        strm_data,
   output logic [15:0] strm_addr,
   output logic [15:0] mem_addr,
   input  vec_t        mem_rd
);

   localparam logic [15:0] AMAX_L = amax_f(IMAGE_WIDTH, IMAGE_HEIGHT, LANES);
   localparam int          SW     = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic          strm_elig, strm_gnt, cpu_oob;
   logic [15:0]   ptr;
   logic [SW-1:0] starve_cnt;

   assign cpu_oob  = cpu_addr > AMAX_L;
   assign strm_gnt = strm_elig & (~cpu_req | (starve_cnt == SMAX));
   assign cpu_gnt  = RST_N & cpu_req & ~strm_gnt;

   always_comb begin
      mem_addr = '0;
      if (RST_N) begin
         if (cpu_gnt)       mem_addr = cpu_addr;
         else if (strm_gnt) mem_addr = ptr;
      end
   end

   // Only CPU wins that actually blocked a ready stream count towards starvation.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                                      starve_cnt <= '0;
      else if (strm_gnt)                               starve_cnt <= '0;
      else if (cpu_gnt & strm_elig & (starve_cnt != SMAX)) starve_cnt <= starve_cnt + 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cpu_rvalid <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         cpu_rvalid <= cpu_gnt;
         cpu_err    <= cpu_gnt & cpu_oob;
         if (cpu_gnt) cpu_rdata <= cpu_oob ? '0 : mem_rd;
      end
   end

   vmem_stream_walker #(.LANES(LANES), .AMAX_L(AMAX_L)) u_walker (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .strm_start (strm_start),
      .strm_gnt   (strm_gnt),
      .mem_rd     (mem_rd),
      .strm_ready (strm_ready),
      .ptr        (ptr),
      .strm_elig  (strm_elig),
      .strm_valid (strm_valid),
      .strm_data  (strm_data),
      .strm_addr  (strm_addr),
      .strm_busy  (strm_busy),
      .strm_done  (strm_done)
   );

endmodule

// File: tb/tb_vmem_read_arbiter.sv
// Directed bench for vmem_read_arbiter: CPU reads, full scans, CPU contention, stall and mid-scan reset.
module tb_vmem_read_arbiter;
   import vmem_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        cpu_req = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic        cpu_gnt, cpu_rvalid, cpu_err;
   vec_t        cpu_rdata;
   logic        strm_start = 1'b0;
   logic        strm_busy, strm_done, strm_valid;
   logic        strm_ready = 1'b0;
   vec_t        strm_data;
   logic [15:0] strm_addr, mem_addr;
   vec_t        mem_rd;

   int total = 0;
   int bad   = 0;

   vmem_read_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .strm_start(strm_start), .strm_busy(strm_busy), .strm_done(strm_done),
      .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_data(strm_data),
      .strm_addr(strm_addr), .mem_addr(mem_addr), .mem_rd(mem_rd)
   );

   always #5 CLK = ~CLK;

   // Image byte at address a; low byte xor high byte keeps neighbouring rows distinct.
   function automatic logic [7:0] pix(input int a);
      logic [15:0] x;
      x = 16'(a);
      return x[7:0] ^ x[15:8];
   endfunction

   function automatic vec_t exp_vec(input logic [15:0] a);
      vec_t v;
      v = '0;
      for (int i = 0; i < 8; i++)
         if (int'(a) + i < 9216) v[i] = {8'h00, pix(int'(a) + i)};
      return v;
   endfunction

   always_comb mem_rd = exp_vec(mem_addr);

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // cpu_on: hold cpu_req high; stall_hs: chunk index held with ready low for 10 cycles;
   // abort_hs: chunk index at which reset is asserted. -1 disables.
   task automatic run_scan(input string tag, input bit cpu_on, input int stall_hs, input int abort_hs);
      int hs = 0, nvalid = 0, ndone = 0, first_v = -1, done_c = -1, nstall = 0;
      int addr_err = 0, data_err = 0, gnt_err = 0, rsp_err = 0, stall_err = 0, busy_err = 0, sgnt = 0;
      int exp_first, exp_nvalid;
      bit pend = 0, rdy, exp_g;
      logic [15:0] pend_a = '0, hold_a = '0, a;
      vec_t hold_d = '0;
      exp_first  = cpu_on ? 6 : 2;
      exp_nvalid = 1152 + ((stall_hs >= 0) ? 10 : 0);
      for (int c = 0; c < 7000 && done_c < 0; c++) begin
         @(negedge CLK);
         if (strm_done) begin ndone++; done_c = c; end
         if (c == 1 && strm_busy !== 1'b1) busy_err++;
         if (c == 0 && strm_busy !== 1'b0) busy_err++;
         if (cpu_on) begin
            if (cpu_rvalid !== pend) rsp_err++;
            else if (pend && (cpu_rdata !== ((pend_a > 16'd9208) ? vec_t'('0) : exp_vec(pend_a)) ||
                              cpu_err !== (pend_a > 16'd9208))) rsp_err++;
         end
         if (abort_hs >= 0 && hs == abort_hs) begin
            RST_N = 1'b0;
            #1;
            chk({tag, "_rst_outs"}, {cpu_gnt, cpu_rvalid, cpu_err, strm_busy, strm_done, strm_valid}, 6'b0);
            chk({tag, "_rst_bus"}, {cpu_rdata, strm_data, strm_addr, mem_addr}, '0);
            chk({tag, "_pre_addr_err"}, addr_err, 0);
            chk({tag, "_pre_data_err"}, data_err, 0);
            strm_start = 1'b0;
            ndone = 0;
            repeat (3) begin @(negedge CLK); if (strm_done) ndone++; end
            RST_N = 1'b1;
            repeat (4) begin @(negedge CLK); if (strm_done || strm_busy || strm_valid) ndone++; end
            chk({tag, "_no_done"}, ndone, 0);
            return;
         end
         if (strm_valid) begin
            if (first_v < 0) first_v = c;
            nvalid++;
            if (strm_data !== exp_vec(strm_addr)) data_err++;
         end
         rdy = 1'b1;
         if (strm_valid && hs == stall_hs && nstall < 10) begin
            if (nstall == 0) begin hold_a = strm_addr; hold_d = strm_data; end
            else if (strm_addr !== hold_a || strm_data !== hold_d) stall_err++;
            nstall++;
            rdy = 1'b0;
         end
         if (strm_valid && rdy) begin
            if (int'(strm_addr) != hs * 8) addr_err++;
            hs++;
         end
         a = 16'((c * 1237 + 16) % 9300);
         strm_start = (c == 0);
         strm_ready = rdy;
         cpu_req    = cpu_on;
         cpu_addr   = a;
         #1;
         exp_g = cpu_on && !(c >= 5 && c % 5 == 0 && c <= 5760);
         if (cpu_on && !exp_g) sgnt++;
         if (cpu_gnt !== exp_g) gnt_err++;
         pend   = exp_g;
         pend_a = a;
      end
      @(negedge CLK);
      cpu_req = 1'b0;
      strm_start = 1'b0;
      chk({tag, "_first_valid"}, first_v, exp_first);
      chk({tag, "_done_cycle"}, done_c, cpu_on ? 5762 : (exp_first + exp_nvalid));
      chk({tag, "_done_once"}, ndone, 1);
      chk({tag, "_chunks"}, hs, 1152);
      chk({tag, "_nvalid"}, nvalid, cpu_on ? 1152 : exp_nvalid);
      chk({tag, "_addr_err"}, addr_err, 0);
      chk({tag, "_data_err"}, data_err, 0);
      chk({tag, "_gnt_err"}, gnt_err, 0);
      chk({tag, "_busy_err"}, busy_err, 0);
      chk({tag, "_busy_end"}, strm_busy, 1'b0);
      if (cpu_on) begin
         chk({tag, "_rsp_err"}, rsp_err, 0);
         chk({tag, "_strm_slots"}, sgnt, 1152);
      end
      if (stall_hs >= 0) begin
         chk({tag, "_stall_cycles"}, nstall, 10);
         chk({tag, "_stall_err"}, stall_err, 0);
      end
   endtask

   initial begin
      vec_t v16;
      v16 = '0;
      for (int i = 0; i < 8; i++) v16[i] = 16'h0010 + 16'(i);

      // Reset: a pending CPU request must not be granted.
      cpu_req  = 1'b1;
      cpu_addr = 16'd16;
      #12;
      chk("rst_gnt", cpu_gnt, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'd0);
      chk("rst_outs", {cpu_rvalid, cpu_err, strm_busy, strm_done, strm_valid}, 5'b0);
      chk("rst_bus", {cpu_rdata, strm_data, strm_addr}, '0);
      @(negedge CLK);
      cpu_req = 1'b0;
      RST_N   = 1'b1;
      @(negedge CLK);

      // CPU reads: addr 16, then out-of-range 9209, then boundary 9208, back to back.
      cpu_req  = 1'b1;
      cpu_addr = 16'd16;
      #1;
      chk("gnt16", cpu_gnt, 1'b1);
      chk("mem_addr16", mem_addr, 16'd16);
      @(negedge CLK);
      chk("rvalid16", cpu_rvalid, 1'b1);
      chk("rdata16", cpu_rdata, v16);
      chk("err16", cpu_err, 1'b0);
      cpu_addr = 16'd9209;
      @(negedge CLK);
      chk("rvalid9209", cpu_rvalid, 1'b1);
      chk("err9209", cpu_err, 1'b1);
      chk("rdata9209", cpu_rdata, '0);
      cpu_addr = 16'd9208;
      @(negedge CLK);
      chk("err9208", cpu_err, 1'b0);
      chk("rdata9208", cpu_rdata, exp_vec(16'd9208));
      cpu_req = 1'b0;
      @(negedge CLK);
      chk("rvalid_idle", cpu_rvalid, 1'b0);

      run_scan("scan", 1'b0, -1, -1);
      run_scan("cpuscan", 1'b1, -1, -1);
      run_scan("stall", 1'b0, 300, -1);
      run_scan("abort", 1'b0, -1, 500);
      run_scan("restart", 1'b0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
